// File: rtl/mips150_mem_pkg.sv
// Shared encodings for the MIPS150 memory stage: load mask codes,
// store-width codes and the load/store unit FSM state type.
package mips150_mem_pkg;

    // Load mask codes produced by the control decoder
    localparam logic [2:0] MASK_LB  = 3'b000;
    localparam logic [2:0] MASK_LH  = 3'b001;
    localparam logic [2:0] MASK_LW  = 3'b010;
    localparam logic [2:0] MASK_LBU = 3'b011;
    localparam logic [2:0] MASK_LHU = 3'b100;

    // Store width codes produced by the control decoder
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SW   = 2'b11;

    // Load/store unit FSM: idle, or waiting for read data from memory
    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/load_extract.sv
// Combinational load-data aligner: picks the addressed byte/half out of a
// big-endian memory word and sign- or zero-extends it. Also used by the
// writeback bypass, so it carries no state.
module load_extract
    import mips150_mem_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [2:0]  mask,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: offset 0 is the most significant byte
    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0: byte_sel = dout[31:24];
            2'd1: byte_sel = dout[23:16];
            2'd2: byte_sel = dout[15:8];
            2'd3: byte_sel = dout[7:0];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? dout[15:0] : dout[31:16];
    end

    // Extension according to the load mask; unknown masks yield zero
    always_comb begin
        result = 32'h0;
        case (mask)
            MASK_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MASK_LH:  result = {{16{half_sel[15]}}, half_sel};
            MASK_LW:  result = dout;
            MASK_LBU: result = {24'h0, byte_sel};
            MASK_LHU: result = {16'h0, half_sel};
            default:  result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit. Drives the data memory directly from the
// X-stage request, waits for read data on loads, returns the aligned load
// result and traps misaligned accesses with a sticky flag.
//
// Handshake: a request issues when x_valid=1 and stall=0. A load issued in
// cycle N completes in the first LOAD_WAIT cycle with dmem_ready=1, where
// m_load_valid pulses for exactly that cycle; stall is high in every
// LOAD_WAIT cycle without dmem_ready, and no new request issues while it is.
module mem_access_unit
    import mips150_mem_pkg::*;
#(
    parameter int DMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x_valid,
    input  logic               x_mem_read,
    input  logic [1:0]         x_mem_write,
    input  logic [2:0]         x_mask,
    input  logic [31:0]        x_addr,
    input  logic [31:0]        x_store_data,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    input  logic               dmem_ready,
    output logic [31:0]        m_load_data,
    output logic               m_load_valid,
    output logic               stall,
    output logic               misalign_err,
    output logic [31:0]        misalign_addr,
    output state_t             dbg_state
);

    state_t      state, next_state;
    logic [2:0]  lat_mask;
    logic [1:0]  lat_off;

    logic        is_store, is_load, misaligned;
    logic [3:0]  store_we;
    logic        issue, access_ok, misalign_hit, load_issue, load_done;
    logic [31:0] extracted;

    assign dbg_state = state;
    assign dmem_addr = x_addr[DMEM_AW+1:2];

    // Decode the X request: store priority, lane enables, replicated data, alignment
    always_comb begin
        is_store   = (x_mem_write != MW_NONE);
        is_load    = !is_store && x_mem_read;
        store_we   = 4'b0000;
        dmem_din   = x_store_data;
        misaligned = 1'b0;
        case (x_mem_write)
            MW_SB: begin
                store_we = 4'b1000 >> x_addr[1:0];
                dmem_din = {4{x_store_data[7:0]}};
            end
            MW_SH: begin
                store_we   = x_addr[1] ? 4'b0011 : 4'b1100;
                dmem_din   = {2{x_store_data[15:0]}};
                misaligned = x_addr[0];
            end
            MW_SW: begin
                store_we   = 4'b1111;
                misaligned = (x_addr[1:0] != 2'b00);
            end
            default: begin
                // Loads: halfword and word masks carry alignment constraints
                if (x_mask == MASK_LH || x_mask == MASK_LHU)
                    misaligned = x_addr[0];
                else if (x_mask == MASK_LW)
                    misaligned = (x_addr[1:0] != 2'b00);
            end
        endcase
    end

    load_extract u_extract (
        .dout   (dmem_dout),
        .mask   (lat_mask),
        .offset (lat_off),
        .result (extracted)
    );

    // FSM next state and handshake outputs; everything is held low in reset
    always_comb begin
        next_state   = state;
        load_done    = rst_n && (state == ST_LOAD_WAIT) && dmem_ready;
        stall        = rst_n && (state == ST_LOAD_WAIT) && !dmem_ready;
        issue        = rst_n && x_valid && !stall;
        access_ok    = issue && (is_store || is_load) && !misaligned;
        misalign_hit = issue && (is_store || is_load) && misaligned;
        load_issue   = access_ok && is_load;
        dmem_en      = access_ok;
        dmem_we      = (access_ok && is_store) ? store_we : 4'b0000;
        m_load_valid = load_done;
        m_load_data  = load_done ? extracted : 32'h0;
        case (state)
            ST_IDLE: begin
                if (load_issue)
                    next_state = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (load_done)
                    next_state = load_issue ? ST_LOAD_WAIT : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register, load context latch and sticky misalignment capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lat_mask      <= 3'b000;
            lat_off       <= 2'b00;
            misalign_err  <= 1'b0;
            misalign_addr <= 32'h0;
        end else begin
            state <= next_state;
            if (load_issue) begin
                lat_mask <= x_mask;
                lat_off  <= x_addr[1:0];
            end
            if (misalign_hit) begin
                misalign_err <= 1'b1;
                if (!misalign_err)
                    misalign_addr <= x_addr;
            end
        end
    end

endmodule
